// File: rtl/prism_in_cond_if.sv
// Register-access bus for prism_in_cond: one-cycle write strobe plus a
// combinational read port selected by cfg_addr.
interface prism_in_cond_if;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;

  modport master (output cfg_wr, cfg_addr, cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_wr, cfg_addr, cfg_wdata, output cfg_rdata);
endinterface

// File: rtl/prism_in_cond.sv
// prism_in_cond: input conditioning ahead of the PRISM FSM input bus.
// Each channel gets a two-flop synchronizer, an optional glitch filter and
// rise/fall edge qualification producing one-cycle pulses. Qualified edges
// set sticky event flags that drive a maskable interrupt.
// Optional feature macro: PRISM_IN_COND_FILTER_EN builds the glitch filter
// counters and the FILT register; without it level follows the synchronizer.
module prism_in_cond #(
  parameter int WIDTH  = 8,
  parameter int FILT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  prism_in_cond_if.slave   cfg,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] edge_out,
  output logic             event_irq
);

  localparam logic [1:0] ADDR_FILT  = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_EVENT = 2'd2;
  localparam logic [1:0] ADDR_MASK  = 2'd3;

  logic [WIDTH-1:0]   sync1;
  logic [WIDTH-1:0]   sync_s;
  logic [WIDTH-1:0]   level_nxt;
  logic [WIDTH-1:0]   rise_sel;
  logic [WIDTH-1:0]   fall_sel;
  logic [WIDTH-1:0]   w1c;
  logic [WIDTH-1:0]   event_flags;
  logic [WIDTH-1:0]   mask;
  logic [2*WIDTH-1:0] edge_sel;
  logic               wr_edge;
  logic               wr_event;
  logic               wr_mask;
  logic               unused_bits;

  assign wr_edge  = cfg.cfg_wr && (cfg.cfg_addr == ADDR_EDGE);
  assign wr_event = cfg.cfg_wr && (cfg.cfg_addr == ADDR_EVENT);
  assign wr_mask  = cfg.cfg_wr && (cfg.cfg_addr == ADDR_MASK);
  assign w1c      = wr_event ? cfg.cfg_wdata[WIDTH-1:0] : '0;

  // Upper write-data bits have no register behind them.
  assign unused_bits = ^cfg.cfg_wdata;

  // Split the packed 2-bit-per-channel EDGE_SEL into rise/fall enables.
  always_comb begin
    rise_sel = '0;
    fall_sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rise_sel[i] = edge_sel[2*i];
      fall_sel[i] = edge_sel[2*i+1];
    end
  end

`ifdef PRISM_IN_COND_FILTER_EN
  logic              wr_filt;
  logic [FILT_W-1:0] thresh;
  logic [WIDTH-1:0]  filt_en;
  logic [FILT_W-1:0] cnt [WIDTH];

  assign wr_filt = cfg.cfg_wr && (cfg.cfg_addr == ADDR_FILT);

  // FILT register and per-channel run-length counters; a FILT write restarts every count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thresh  <= '0;
      filt_en <= '0;
      // NOTE: this counter array is a small flop bank, not a RAM, so resetting every entry is cheap and required.
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      if (wr_filt) begin
        thresh  <= cfg.cfg_wdata[FILT_W-1:0];
        filt_en <= cfg.cfg_wdata[8 +: WIDTH];
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_filt || !filt_en[i] || (sync_s[i] == level_out[i]) || (cnt[i] == thresh))
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Next level: follow s directly, or only once s has differed for thresh+1 cycles.
  always_comb begin
    // NOTE: default assignment first so every path drives level_nxt and no latch is inferred.
    level_nxt = level_out;
    for (int i = 0; i < WIDTH; i++) begin
      if (!filt_en[i])
        level_nxt[i] = sync_s[i];
      else if (!wr_filt && (sync_s[i] != level_out[i]) && (cnt[i] == thresh))
        level_nxt[i] = sync_s[i];
    end
  end
`else
  localparam int UNUSED_FILT_W = FILT_W;

  // Without the filter the level is simply the synchronized pin.
  always_comb begin
    level_nxt = sync_s;
  end
`endif

  // Synchronizer, level/edge pipeline, config registers, sticky events and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync_s      <= '0;
      level_out   <= '0;
      edge_out    <= '0;
      edge_sel    <= '0;
      mask        <= '0;
      event_flags <= '0;
      event_irq   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync1 -> sync_s a real two-stage shift, not a wire.
      sync1     <= pin_in;
      sync_s    <= sync1;
      level_out <= level_nxt;
      edge_out  <= (level_nxt & ~level_out & rise_sel) |
                   (~level_nxt & level_out & fall_sel);
      if (wr_edge) edge_sel <= cfg.cfg_wdata[2*WIDTH-1:0];
      if (wr_mask) mask     <= cfg.cfg_wdata[WIDTH-1:0];
      // A new edge outranks a simultaneous write-1-to-clear.
      event_flags <= (event_flags & ~w1c) | edge_out;
      event_irq   <= |(event_flags & mask);
    end
  end

  // Combinational register read-back.
  always_comb begin
    cfg.cfg_rdata = '0;
    case (cfg.cfg_addr)
      ADDR_FILT: begin
`ifdef PRISM_IN_COND_FILTER_EN
        cfg.cfg_rdata[FILT_W-1:0] = thresh;
        cfg.cfg_rdata[8 +: WIDTH] = filt_en;
`endif
      end
      ADDR_EDGE:  cfg.cfg_rdata[2*WIDTH-1:0] = edge_sel;
      ADDR_EVENT: cfg.cfg_rdata[WIDTH-1:0]   = event_flags;
      ADDR_MASK:  cfg.cfg_rdata[WIDTH-1:0]   = mask;
      default:    cfg.cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_prism_in_cond.sv
// Directed bench for prism_in_cond (WIDTH=8, FILT_W=4). Filter scenarios
// follow PRISM_IN_COND_FILTER_EN; the default build checks the filter is absent.
module tb_prism_in_cond;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pin_in = '0;
  logic [7:0] level_out;
  logic [7:0] edge_out;
  logic       event_irq;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  prism_in_cond_if cfg_if ();

  prism_in_cond #(.WIDTH(8), .FILT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_in    (pin_in),
    .cfg       (cfg_if),
    .level_out (level_out),
    .edge_out  (edge_out),
    .event_irq (event_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_if.cfg_wr    = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_wdata = d;
    tick(1);
    cfg_if.cfg_wr    = 1'b0;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_if.cfg_addr = a;
    #1;
    d = cfg_if.cfg_rdata;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pin_in = '0;
    cfg_if.cfg_wr = 1'b0;
    cfg_if.cfg_addr = 2'd0;
    cfg_if.cfg_wdata = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    pin_in = 8'hFF;
    cfg_if.cfg_wr = 1'b0;
    cfg_if.cfg_addr = 2'd0;
    cfg_if.cfg_wdata = '0;
    tick(3);
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL rst_level: got %h want 00", level_out); else pass_cnt++;
    chk_cnt++; if (edge_out !== 8'h00) $display("FAIL rst_edge: got %h want 00", edge_out); else pass_cnt++;
    chk_cnt++; if (event_irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", event_irq); else pass_cnt++;
    pin_in = 8'h00;
    rst = 1'b0;
    tick(1);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], d);
      chk_cnt++; if (d !== 32'h0) $display("FAIL rst_reg%0d: got %h want 0", a, d); else pass_cnt++;
    end
  endtask

  task automatic test_unfiltered_rise();
    logic [31:0] d;
    apply_reset();
    wr(2'd1, 32'h0000_0001);
    pin_in = 8'h01;
    tick(2);
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL unf_level_e1: got %h want 00", level_out); else pass_cnt++;
    tick(1);
    chk_cnt++; if (level_out !== 8'h01) $display("FAIL unf_level_e2: got %h want 01", level_out); else pass_cnt++;
    chk_cnt++; if (edge_out !== 8'h01) $display("FAIL unf_edge_e2: got %h want 01", edge_out); else pass_cnt++;
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL unf_event_e2: got %h want 0", d); else pass_cnt++;
    tick(1);
    chk_cnt++; if (edge_out !== 8'h00) $display("FAIL unf_edge_e3: got %h want 00", edge_out); else pass_cnt++;
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h1) $display("FAIL unf_event_e3: got %h want 1", d); else pass_cnt++;
    tick(1);
    chk_cnt++; if (event_irq !== 1'b0) $display("FAIL unf_irq_masked: got %b want 0", event_irq); else pass_cnt++;
  endtask

  task automatic test_event_irq();
    logic [31:0] d;
    apply_reset();
    wr(2'd1, 32'h0000_0030);
    wr(2'd3, 32'h0000_0004);
    pin_in = 8'h04;
    tick(3);
    chk_cnt++; if (edge_out !== 8'h04) $display("FAIL irq_edge_rise: got %h want 04", edge_out); else pass_cnt++;
    tick(1);
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h4) $display("FAIL irq_event_set: got %h want 4", d); else pass_cnt++;
    chk_cnt++; if (event_irq !== 1'b0) $display("FAIL irq_not_yet: got %b want 0", event_irq); else pass_cnt++;
    tick(1);
    chk_cnt++; if (event_irq !== 1'b1) $display("FAIL irq_set: got %b want 1", event_irq); else pass_cnt++;
    wr(2'd2, 32'h0000_0004);
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL irq_w1c_flag: got %h want 0", d); else pass_cnt++;
    chk_cnt++; if (event_irq !== 1'b1) $display("FAIL irq_w1c_edge1: got %b want 1", event_irq); else pass_cnt++;
    tick(1);
    chk_cnt++; if (event_irq !== 1'b0) $display("FAIL irq_w1c_edge2: got %b want 0", event_irq); else pass_cnt++;
    pin_in = 8'h00;
    tick(3);
    chk_cnt++; if (edge_out !== 8'h04) $display("FAIL irq_edge_fall: got %h want 04", edge_out); else pass_cnt++;
    wr(2'd2, 32'h0000_0004);
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h4) $display("FAIL irq_set_wins: got %h want 4", d); else pass_cnt++;
    tick(1);
    chk_cnt++; if (event_irq !== 1'b1) $display("FAIL irq_after_race: got %b want 1", event_irq); else pass_cnt++;
  endtask

  task automatic test_fall_only();
    logic [31:0] d;
    int pulses;
    int any_edges;
    apply_reset();
    wr(2'd1, 32'h0000_0800);
    pin_in = 8'h20;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (edge_out[5]) pulses++;
    end
    chk_cnt++; if (pulses !== 0) $display("FAIL fall_rise_pulses: got %0d want 0", pulses); else pass_cnt++;
    chk_cnt++; if (level_out !== 8'h20) $display("FAIL fall_level_hi: got %h want 20", level_out); else pass_cnt++;
    pin_in = 8'h00;
    pulses = 0;
    any_edges = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (edge_out[5]) pulses++;
      if (edge_out != 8'h00) any_edges++;
    end
    chk_cnt++; if (pulses !== 1) $display("FAIL fall_fall_pulses: got %0d want 1", pulses); else pass_cnt++;
    chk_cnt++; if (any_edges !== 1) $display("FAIL fall_edge_cycles: got %0d want 1", any_edges); else pass_cnt++;
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL fall_level_lo: got %h want 00", level_out); else pass_cnt++;
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h20) $display("FAIL fall_event: got %h want 20", d); else pass_cnt++;
  endtask

`ifdef PRISM_IN_COND_FILTER_EN
  task automatic test_filter_glitch();
    logic [31:0] d;
    int hits;
    apply_reset();
    wr(2'd0, 32'h0000_0403);
    rd(2'd0, d);
    chk_cnt++; if (d !== 32'h403) $display("FAIL filt_readback: got %h want 403", d); else pass_cnt++;
    wr(2'd1, 32'h0000_0030);
    pin_in = 8'h04;
    tick(3);
    pin_in = 8'h00;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (level_out[2] || edge_out[2]) hits++;
    end
    chk_cnt++; if (hits !== 0) $display("FAIL filt_glitch_hits: got %0d want 0", hits); else pass_cnt++;
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL filt_glitch_event: got %h want 0", d); else pass_cnt++;
    pin_in = 8'h04;
    tick(4);
    pin_in = 8'h00;
    tick(1);
    chk_cnt++; if (level_out[2] !== 1'b0) $display("FAIL filt_e4_level: got %b want 0", level_out[2]); else pass_cnt++;
    tick(1);
    chk_cnt++; if (level_out[2] !== 1'b1) $display("FAIL filt_e5_level: got %b want 1", level_out[2]); else pass_cnt++;
    chk_cnt++; if (edge_out[2] !== 1'b1) $display("FAIL filt_e5_edge: got %b want 1", edge_out[2]); else pass_cnt++;
    tick(3);
    chk_cnt++; if ({level_out[2], edge_out[2]} !== 2'b10) $display("FAIL filt_e8_state: got %b want 10", {level_out[2], edge_out[2]}); else pass_cnt++;
    tick(1);
    chk_cnt++; if ({level_out[2], edge_out[2]} !== 2'b01) $display("FAIL filt_e9_fall: got %b want 01", {level_out[2], edge_out[2]}); else pass_cnt++;
  endtask

  task automatic test_filter_rewrite();
    apply_reset();
    wr(2'd0, 32'h0000_0403);
    pin_in = 8'h04;
    tick(4);
    wr(2'd0, 32'h0000_0403);
    tick(3);
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL rewr_e7_level: got %h want 00", level_out); else pass_cnt++;
    tick(1);
    chk_cnt++; if (level_out !== 8'h04) $display("FAIL rewr_e8_level: got %h want 04", level_out); else pass_cnt++;
  endtask
`else
  task automatic test_filter_absent();
    logic [31:0] d;
    apply_reset();
    wr(2'd0, 32'h0000_0403);
    rd(2'd0, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL nofilt_read: got %h want 0", d); else pass_cnt++;
    pin_in = 8'h04;
    tick(2);
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL nofilt_e1_level: got %h want 00", level_out); else pass_cnt++;
    tick(1);
    chk_cnt++; if (level_out !== 8'h04) $display("FAIL nofilt_e2_level: got %h want 04", level_out); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid_count();
    logic [31:0] d;
    int edges;
    apply_reset();
`ifdef PRISM_IN_COND_FILTER_EN
    wr(2'd0, 32'h0000_0403);
`endif
    wr(2'd1, 32'h0000_0001);
    wr(2'd3, 32'h0000_0001);
    pin_in = 8'h01;
    tick(5);
    chk_cnt++; if (event_irq !== 1'b1) $display("FAIL rmid_pre_irq: got %b want 1", event_irq); else pass_cnt++;
    pin_in = 8'h05;
    tick(4);
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL rmid_level: got %h want 00", level_out); else pass_cnt++;
    chk_cnt++; if (event_irq !== 1'b0) $display("FAIL rmid_irq: got %b want 0", event_irq); else pass_cnt++;
    rd(2'd2, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL rmid_event: got %h want 0", d); else pass_cnt++;
    #2;
    rst = 1'b0;
    edges = 0;
    tick(2);
    if (edge_out != 8'h00) edges++;
    chk_cnt++; if (level_out !== 8'h00) $display("FAIL rmid_e1_level: got %h want 00", level_out); else pass_cnt++;
    tick(1);
    if (edge_out != 8'h00) edges++;
    chk_cnt++; if (level_out !== 8'h05) $display("FAIL rmid_e2_level: got %h want 05", level_out); else pass_cnt++;
    tick(1);
    if (edge_out != 8'h00) edges++;
    chk_cnt++; if (edges !== 0) $display("FAIL rmid_edges: got %0d want 0", edges); else pass_cnt++;
    rd(2'd1, d);
    chk_cnt++; if (d !== 32'h0) $display("FAIL rmid_edgesel: got %h want 0", d); else pass_cnt++;
  endtask

  initial begin
    cfg_if.cfg_wr    = 1'b0;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_wdata = '0;
    test_reset();
    test_unfiltered_rise();
    test_event_irq();
    test_fall_only();
`ifdef PRISM_IN_COND_FILTER_EN
    test_filter_glitch();
    test_filter_rewrite();
`else
    test_filter_absent();
`endif
    test_reset_mid_count();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
